// File: rtl/sigmul_pkg.sv
// Purpose: shared types and elaboration-time helpers for the radix-4 Booth
//          significand multiplier (group count, sign-correction constant,
//          Booth digit encoding).
// Contents: booth_code_t, MAG_* magnitude codes, booth_groups(), booth_corr(),
//           booth_encode().
package sigmul_pkg;

  localparam int unsigned MAX_W = 24;

  // Magnitude part of a Booth digit; sign is carried separately in neg.
  localparam logic [1:0] MAG_ZERO   = 2'b00;
  localparam logic [1:0] MAG_SINGLE = 2'b01;
  localparam logic [1:0] MAG_DOUBLE = 2'b10;

  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } booth_code_t;

  function automatic int unsigned booth_groups(input int unsigned w);
    return w / 2 + 1;
  endfunction

  // Each row keeps only an inverted MSB at weight 2^(w+1+2k); subtracting
  // that weight for every row restores the two's-complement value.
  function automatic logic [2*MAX_W-1:0] booth_corr(input int unsigned w);
    logic [63:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < booth_groups(w); k++) begin
      acc = acc - (64'd1 << (w + 1 + 2 * k));
    end
    return acc[2*MAX_W-1:0];
  endfunction

  // Digit value = -2*b[2] + b[1] + b[0]; the zero digits never set neg.
  function automatic booth_code_t booth_encode(input logic [2:0] b);
    booth_code_t c;
    c.neg = b[2] & ~(b[1] & b[0]);
    case (b)
      3'b001, 3'b010, 3'b101, 3'b110: c.mag = MAG_SINGLE;
      3'b011, 3'b100:                 c.mag = MAG_DOUBLE;
      default:                        c.mag = MAG_ZERO;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_pp_row.sv
// Purpose: one radix-4 Booth partial-product row.
// Ports: grp_i  3-bit overlapping multiplicand group
//        y_i    extended selected operand (WIDTH+1 bits)
//        row_o  WIDTH+1 selected/inverted bits plus inverted sign MSB
//        neg_o  +1 to be added at the row LSB when the digit is negative
module booth_pp_row
  import sigmul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       grp_i,
  input  logic [WIDTH:0]   y_i,
  output logic [WIDTH+1:0] row_o,
  output logic             neg_o
);

  booth_code_t    code;
  logic           sgl;
  logic           dbl;
  logic           top;
  logic [WIDTH:0] sel;

  assign code = booth_encode(grp_i);
  assign sgl  = (code.mag == MAG_SINGLE);
  assign dbl  = (code.mag == MAG_DOUBLE);
  assign sel  = ({(WIDTH+1){sgl}} & y_i) | ({(WIDTH+1){dbl}} & {y_i[WIDTH-1:0], 1'b0});

  // Sign bit of the selected value one position above the selectors.
  assign top   = (sgl | dbl) & y_i[WIDTH];
  assign row_o = {~(top ^ code.neg), sel ^ {(WIDTH+1){code.neg}}};
  assign neg_o = code.neg;

endmodule

// File: rtl/booth_r4_sigmul_pipe.sv
// Purpose: radix-4 Booth significand multiplier with optional pipeline
//          registers (after PP generation, CSA tree, CPA) and a global-stall
//          valid/ready handshake. Unsigned or two's complement per transaction.
// Ports: CLK/RST (async active-low), flush (drop in-flight work),
//        in_valid/in_ready with mx, my, tc_mode; out_valid/out_ready with
//        product = mx*my modulo 2^(2*WIDTH).
module booth_r4_sigmul_pipe
  import sigmul_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mx,
  input  logic [WIDTH-1:0]   my,
  input  logic               tc_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned G  = booth_groups(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NR = G + 2;
  localparam logic [2*MAX_W-1:0] CORR_FULL = booth_corr(WIDTH);
  localparam logic [PW-1:0]      CORR      = CORR_FULL[PW-1:0];

  logic adv;

  // Operand extension: mx gets the implicit zero below bit 0.
  logic [WIDTH+2:0] xe;
  logic [WIDTH:0]   ye;
  assign xe = {{2{tc_mode & mx[WIDTH-1]}}, mx, 1'b0};
  assign ye = {tc_mode & my[WIDTH-1], my};

  // Partial-product generation: G Booth rows, a neg-bit row, the correction row.
  logic [WIDTH+1:0] row [G];
  logic [G-1:0]     neg;
  logic [PW-1:0]    neg_row;
  logic [PW-1:0]    pp_d [NR];

  for (genvar k = 0; k < G; k++) begin : g_rows
    booth_pp_row #(.WIDTH(WIDTH)) u_row (
      .grp_i (xe[2*k+2 -: 3]),
      .y_i   (ye),
      .row_o (row[k]),
      .neg_o (neg[k])
    );
    assign pp_d[k]               = PW'(row[k]) << (2 * k);
    assign neg_row[2*k+1 -: 2]   = {1'b0, neg[k]};
  end
  assign neg_row[PW-1:2*G] = '0;
  assign pp_d[G]           = neg_row;
  assign pp_d[G+1]         = CORR;

  // S1: after PP generation.
  logic          v1;
  logic [PW-1:0] pp1 [NR];
  if (PIPE_STAGES >= 1) begin : g_s1
    logic          v1_q;
    logic [PW-1:0] pp_q [NR];
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        v1_q <= 1'b0;
        pp_q <= '{default: '0};
      end else begin
        if (flush)    v1_q <= 1'b0;
        else if (adv) v1_q <= in_valid;
        if (adv && !flush) pp_q <= pp_d;
      end
    end
    assign v1  = v1_q;
    assign pp1 = pp_q;
  end else begin : g_s1_bypass
    assign v1  = in_valid;
    assign pp1 = pp_d;
  end

  // Carry-save array: fold one row per level into the running sum/carry pair.
  logic [PW-1:0] cs_s [NR-1];
  logic [PW-1:0] cs_c [NR-1];
  assign cs_s[0] = pp1[0];
  assign cs_c[0] = pp1[1];
  for (genvar i = 1; i < NR - 1; i++) begin : g_csa
    assign cs_s[i] = cs_s[i-1] ^ cs_c[i-1] ^ pp1[i+1];
    assign cs_c[i] = ((cs_s[i-1] & cs_c[i-1]) | (cs_s[i-1] & pp1[i+1]) |
                      (cs_c[i-1] & pp1[i+1])) << 1;
  end

  // S2: after the CSA tree.
  logic          v2;
  logic [PW-1:0] sum2;
  logic [PW-1:0] carry2;
  if (PIPE_STAGES >= 2) begin : g_s2
    logic          v2_q;
    logic [PW-1:0] sum_q;
    logic [PW-1:0] carry_q;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        v2_q    <= 1'b0;
        sum_q   <= '0;
        carry_q <= '0;
      end else begin
        if (flush)    v2_q <= 1'b0;
        else if (adv) v2_q <= v1;
        if (adv && !flush) begin
          sum_q   <= cs_s[NR-2];
          carry_q <= cs_c[NR-2];
        end
      end
    end
    assign v2     = v2_q;
    assign sum2   = sum_q;
    assign carry2 = carry_q;
  end else begin : g_s2_bypass
    assign v2     = v1;
    assign sum2   = cs_s[NR-2];
    assign carry2 = cs_c[NR-2];
  end

  // Final carry-propagate add, wrapping at 2*WIDTH bits.
  logic [PW-1:0] prod_d;
  assign prod_d = sum2 + carry2;

  // S3: after the CPA.
  if (PIPE_STAGES >= 3) begin : g_s3
    logic          v3_q;
    logic [PW-1:0] prod_q;
    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        v3_q   <= 1'b0;
        prod_q <= '0;
      end else begin
        if (flush)    v3_q <= 1'b0;
        else if (adv) v3_q <= v2;
        if (adv && !flush) prod_q <= prod_d;
      end
    end
    assign out_valid = v3_q;
    assign product   = prod_q;
  end else begin : g_s3_bypass
    assign out_valid = v2;
    assign product   = prod_d;
  end

  // Global stall: every stage advances together or holds together.
  assign adv      = (PIPE_STAGES == 0) ? out_ready : (~out_valid | out_ready);
  assign in_ready = adv;

endmodule

// File: tb/tb_booth_r4_sigmul_pipe.sv
// Purpose: directed self-checking bench for booth_r4_sigmul_pipe (WIDTH=8,
//          PIPE_STAGES=2) plus a scoreboarded random stream.
module tb_booth_r4_sigmul_pipe;

  localparam int unsigned W = 8;
  localparam int unsigned P = 2;

  logic           CLK = 1'b0;
  logic           RST;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   mx;
  logic [W-1:0]   my;
  logic           tc_mode;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int errors = 0;
  int checks = 0;

  logic [7:0]  bp_a [4] = '{8'h03, 8'h10, 8'hAB, 8'h0C};
  logic [7:0]  bp_b [4] = '{8'h05, 8'h10, 8'h02, 8'h0D};
  logic [15:0] bp_e [4] = '{16'h000F, 16'h0100, 16'h0156, 16'h009C};
  logic [7:0]  corner [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

  always #5 CLK = ~CLK;

  booth_r4_sigmul_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mx        (mx),
    .my        (my),
    .tc_mode   (tc_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic tc);
    in_valid = v;
    mx       = a;
    my       = b;
    tc_mode  = tc;
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic tc);
    int sa;
    int sb;
    sa = tc ? int'($signed(a)) : int'(a);
    sb = tc ? int'($signed(b)) : int'(b);
    return 16'(sa * sb);
  endfunction

  // One isolated transaction: accepted, invisible one cycle later, valid after two, gone after three.
  task automatic single(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic tc, input logic [15:0] exp);
    drive(1'b1, a, b, tc);
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    cyc();
    chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_product"}, 32'(product), 32'(exp));
    cyc();
    chk({tag, "_after_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int got;
    int acc;
    int ncyc;
    logic [15:0] q[$];

    RST       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) cyc();
    RST = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Unsigned and signed directed products.
    single("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    single("u_00_a5", 8'h00, 8'hA5, 1'b0, 16'h0000);
    single("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    single("s_ff_01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    single("s_7f_80", 8'h7F, 8'h80, 1'b1, 16'hC080);
    single("u_7f_80", 8'h7F, 8'h80, 1'b0, 16'h3F80);
    single("u_ff_01", 8'hFF, 8'h01, 1'b0, 16'h00FF);
    single("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 16'h0001);

    // Backpressure: out_ready low for the three cycles starting at first out_valid.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 20; c++) begin
      if (sent < 4) drive(1'b1, bp_a[sent], bp_b[sent], 1'b0);
      else          drive(1'b0, '0, '0, 1'b0);
      out_ready = !(c >= 2 && c <= 4);
      #1;
      if (c == 2) chk("bp_first_valid", 32'(out_valid), 32'd1);
      if (out_valid && !out_ready) begin
        chk("bp_stall_in_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_hold", 32'(product), 32'(bp_e[got]));
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        if (got < 4) chk("bp_order", 32'(product), 32'(bp_e[got]));
        else         chk("bp_duplicate", 32'(out_valid), 32'd0);
        got++;
      end
      cyc();
    end
    chk("bp_count", 32'(got), 32'd4);
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0);

    // Asynchronous reset with two transactions in flight.
    drive(1'b1, 8'h21, 8'h03, 1'b0);
    cyc();
    drive(1'b1, 8'h44, 8'h02, 1'b0);
    cyc();
    drive(1'b0, '0, '0, 1'b0);
    RST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_product", 32'(product), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    cyc();
    RST = 1'b1;
    #1;
    chk("rel_rst_out_valid", 32'(out_valid), 32'd0);
    single("post_rst", 8'h12, 8'h34, 1'b0, 16'h03A8);

    // Flush with one transaction in S1 and a same-cycle input.
    drive(1'b1, 8'h09, 8'h09, 1'b0);
    cyc();
    drive(1'b1, 8'h0A, 8'h0A, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("flush_valid_c1", 32'(out_valid), 32'd0);
    cyc();
    chk("flush_valid_c2", 32'(out_valid), 32'd0);
    cyc();
    chk("flush_valid_c3", 32'(out_valid), 32'd0);
    single("post_flush", 8'h05, 8'hFB, 1'b1, 16'hFFE7);

    // Corner operands in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          single($sformatf("corner_m%0d_%0h_%0h", m, corner[i], corner[j]),
                 corner[i], corner[j], 1'(m), model(corner[i], corner[j], 1'(m)));
        end
      end
    end

    // Random stream with random backpressure against a scoreboard queue.
    acc  = 0;
    ncyc = 0;
    while ((acc < 600 || q.size() != 0) && ncyc < 4000) begin
      if (acc < 600 && $urandom_range(3) != 0)
        drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
      else
        drive(1'b0, '0, '0, 1'b0);
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q.push_back(model(mx, my, tc_mode));
        acc++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 32'(out_valid), 32'd0);
        else               chk("rnd_product", 32'(product), 32'(q.pop_front()));
      end
      cyc();
      ncyc++;
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
    chk("rnd_in_time", 32'(ncyc < 4000), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
